// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, the doubleword queue entry type and a bit-count
// helper for the instruction fetch unit.
package fetch_pkg;

    localparam int DADDR_W = 61;    // doubleword address width (PC[63:3])
    localparam int INST_W  = 32;    // instruction width
    localparam int DWORD_W = 64;    // memory read width

    // One buffered doubleword with its address and first word to present.
    typedef struct packed {
        logic [DWORD_W-1:0] data;
        logic [DADDR_W-1:0] addr;
        logic               startWord;
    } fetch_entry_t;

    // Number of set bits; used to count outstanding requests.
    function automatic int popCount(input logic [31:0] bits);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of DEPTH doubleword entries.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             empties the FIFO (wins over push/pop)
//   push, pushEntry   write an entry at the tail
//   pop               remove the head entry
//   headEntry         current head entry (valid when count != 0)
//   nextStartWord     startWord of the entry behind the head
//   count             number of entries held
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               pushEntry,
    input  logic                       pop,
    output fetch_entry_t               headEntry,
    output logic                       nextStartWord,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t          mem_r [DEPTH];
    logic [PW-1:0]         wrPtr_r;
    logic [PW-1:0]         rdPtr_r;
    logic [CW-1:0]         count_r;

    // Entry storage; only written on push, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_r[wrPtr_r] <= pushEntry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wrPtr_r <= wrPtr_r + PW'(1);
            end
            if (pop) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign headEntry     = mem_r[rdPtr_r];
    assign nextStartWord = mem_r[rdPtr_r + PW'(1)].startWord;
    assign count         = count_r;

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch unit. Issues doubleword reads over a fixed-latency
// memory pipe, buffers returned doublewords and presents them as a stream of
// big-endian 32-bit instructions with their PCs. A redirect flushes buffered
// and in-flight fetches and restarts at a new PC.
// Optional feature macro: FETCH_STATS_EN adds statFetches/statDropped counters.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   redirectValid, redirectPc    flush and restart at redirectPc (bits [1:0] ignored)
//   memReadEn, memReadAddr       read request, doubleword address
//   memReadData                  read data, MEM_LAT cycles after request
//   instValid, inst, instPc      instruction stream (zero when not valid)
//   instReady                    consumer accept
//   statFetches, statDropped     (FETCH_STATS_EN) issued / dropped counts
module fetch
    import fetch_pkg::*;
#(
    parameter int          MEM_LAT  = 2,
    parameter int          QDEPTH   = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirectValid,
    input  logic [63:0]          redirectPc,
    output logic                 memReadEn,
    output logic [63:3]          memReadAddr,
    input  logic [DWORD_W-1:0]   memReadData,
    output logic                 instValid,
    output logic [INST_W-1:0]    inst,
    output logic [63:0]          instPc,
    input  logic                 instReady
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]          statFetches,
    output logic [31:0]          statDropped
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [DADDR_W-1:0]  fetchAddr_r;
    logic [DADDR_W-1:0]  respAddr_r;      // address of the next response to arrive
    logic [MEM_LAT-1:0]  inflight_r;
    logic [MEM_LAT-1:0]  inflightNext_s;
    logic                pendingStart_r;  // next push is the first after a restart
    logic                startSel_r;      // its starting word
    logic                headWord_r;
    logic                headWordNext_s;
    logic [CW-1:0]       qCount_s;
    fetch_entry_t        headEntry_s;
    fetch_entry_t        pushEntry_s;
    logic                nextStartWord_s;
    logic                issue_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                flush_s;
    int                  inflightCount_s;
    logic                unused_s;

    // Issue credit: buffered plus outstanding doublewords must fit the queue.
    always_comb begin
        inflightCount_s = popCount(32'(inflight_r));
        if (reset || redirectValid) begin
            issue_s = 1'b0;
        end else begin
            issue_s = (int'(qCount_s) + inflightCount_s) < QDEPTH;
        end
    end

    assign memReadEn   = issue_s;
    assign memReadAddr = fetchAddr_r;

    // Inflight shift: bit 0 takes the new request, the top bit is the response.
    always_comb begin
        inflightNext_s    = '0;
        inflightNext_s[0] = issue_s;
        for (int i = 1; i < MEM_LAT; i++) begin
            inflightNext_s[i] = inflight_r[i-1];
        end
    end

    assign flush_s  = reset || redirectValid;
    assign push_s   = inflight_r[MEM_LAT-1] && !flush_s;
    assign accept_s = instValid && instReady && !flush_s;
    assign pop_s    = accept_s && headWord_r;

    assign pushEntry_s = '{data: memReadData,
                           addr: respAddr_r,
                           startWord: pendingStart_r ? startSel_r : 1'b0};

    // Word select for the head: a newly arriving head starts at its startWord.
    always_comb begin
        headWordNext_s = headWord_r;
        if (push_s && ((qCount_s == '0) || (pop_s && (qCount_s == CW'(1))))) begin
            headWordNext_s = pushEntry_s.startWord;
        end else if (pop_s && (qCount_s > CW'(1))) begin
            headWordNext_s = nextStartWord_s;
        end else if (pop_s) begin
            headWordNext_s = 1'b0;
        end else if (accept_s) begin
            headWordNext_s = 1'b1;
        end else begin
            headWordNext_s = headWord_r;
        end
    end

    // Fetch/response address, inflight pipe and restart bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchAddr_r    <= RESET_PC[63:3];
            respAddr_r     <= RESET_PC[63:3];
            inflight_r     <= '0;
            pendingStart_r <= 1'b1;
            startSel_r     <= RESET_PC[2];
            headWord_r     <= 1'b0;
        end else if (redirectValid) begin
            fetchAddr_r    <= redirectPc[63:3];
            respAddr_r     <= redirectPc[63:3];
            inflight_r     <= '0;
            pendingStart_r <= 1'b1;
            startSel_r     <= redirectPc[2];
            headWord_r     <= 1'b0;
        end else begin
            if (issue_s) begin
                fetchAddr_r <= fetchAddr_r + DADDR_W'(1);
            end
            if (push_s) begin
                respAddr_r     <= respAddr_r + DADDR_W'(1);
                pendingStart_r <= 1'b0;
            end
            inflight_r <= inflightNext_s;
            headWord_r <= headWordNext_s;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) uQueue (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush_s),
        .push          (push_s),
        .pushEntry     (pushEntry_s),
        .pop           (pop_s),
        .headEntry     (headEntry_s),
        .nextStartWord (nextStartWord_s),
        .count         (qCount_s)
    );

    // Instruction presentation; word 0 is the high half (big-endian).
    always_comb begin
        instValid = (qCount_s != '0);
        if (instValid) begin
            inst   = headWord_r ? headEntry_s.data[31:0] : headEntry_s.data[63:32];
            instPc = {headEntry_s.addr, headWord_r, 2'b00};
        end else begin
            inst   = 32'h0;
            instPc = 64'h0;
        end
    end

    assign unused_s = ^{redirectPc[1:0], headEntry_s.startWord};

`ifdef FETCH_STATS_EN
    // Issued-request and redirect-dropped-response counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            statFetches <= 32'd0;
            statDropped <= 32'd0;
        end else begin
            if (issue_s) begin
                statFetches <= statFetches + 32'd1;
            end
            if (redirectValid) begin
                statDropped <= statDropped + 32'(inflightCount_s);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for fetch (MEM_LAT=2, QDEPTH=4,
// RESET_PC=0). The memory model returns, for doubleword address A, the two
// words equal to their own byte addresses, so each inst equals instPc[31:0].
module tb_fetch;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         redirectValid = 1'b0;
    logic [63:0]  redirectPc = 64'h0;
    logic         memReadEn;
    logic [63:3]  memReadAddr;
    logic [63:0]  memReadData;
    logic         instValid;
    logic [31:0]  inst;
    logic [63:0]  instPc;
    logic         instReady = 1'b1;
`ifdef FETCH_STATS_EN
    logic [31:0]  statFetches;
    logic [31:0]  statDropped;
`endif

    int vecs = 0;
    int errs = 0;

    fetch #(.MEM_LAT(2), .QDEPTH(4), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .memReadEn     (memReadEn),
        .memReadAddr   (memReadAddr),
        .memReadData   (memReadData),
        .instValid     (instValid),
        .inst          (inst),
        .instPc        (instPc),
        .instReady     (instReady)
`ifdef FETCH_STATS_EN
        ,
        .statFetches   (statFetches),
        .statDropped   (statDropped)
`endif
    );

    always #5 clk = ~clk;

    // Two-stage memory pipe: data for a request appears two cycles later.
    logic         p0v = 1'b0;
    logic         p1v = 1'b0;
    logic [63:3]  p0a = '0;
    logic [63:3]  p1a = '0;

    function automatic logic [63:0] dw(input logic [63:3] a);
        logic [63:0] b;
        b = {a, 3'b000};
        return {b[31:0], b[31:0] + 32'd4};
    endfunction

    always @(posedge clk) begin
        p0v <= memReadEn;
        p0a <= memReadAddr;
        p1v <= p0v;
        p1a <= p0a;
    end

    assign memReadData = p1v ? dw(p1a) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkInst(input string tag, input logic [63:0] pc);
        chk({tag, "_valid"}, 64'(instValid), 64'h1);
        chk({tag, "_pc"}, instPc, pc);
        chk({tag, "_inst"}, 64'(inst), 64'(pc[31:0]));
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_valid"}, 64'(instValid), 64'h0);
        chk({tag, "_inst"}, 64'(inst), 64'h0);
        chk({tag, "_pc"}, instPc, 64'h0);
    endtask

    // Apply inputs for one cycle at the falling edge, then settle.
    task automatic cyc(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        reset         = r;
        redirectValid = rv;
        redirectPc    = rpc;
        instReady     = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d miscompares=%0d", vecs, errs);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and first stream.
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        chk("rst_en", 64'(memReadEn), 64'h0);
        chk("rst_addr", 64'(memReadAddr), 64'h0);
        chkIdle("rst");
        for (int c = 0; c <= 10; c++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b1);
            if (c <= 3) begin
                chk("s1_en", 64'(memReadEn), 64'h1);
                chk("s1_addr", 64'(memReadAddr), 64'(c));
            end else if (c == 4) begin
                chk("s1_credit", 64'(memReadEn), 64'h0);
            end
            if (c < 3) chkIdle("s1_idle");
            else       chkInst("s1", 64'(4 * (c - 3)));
        end

        // Backpressure: at most QDEPTH requests, then in-order drain.
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        for (int c = 0; c <= 11; c++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b0);
            chk("bp_en", 64'(memReadEn), (c < 4) ? 64'h1 : 64'h0);
        end
        chkInst("bp_hold", 64'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b1);
            chkInst("bp_drain", 64'(4 * k));
        end

        // Redirect to 0x104 with two responses in flight.
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 1'b1, 64'h104, 1'b1);
        chk("rd_noreq", 64'(memReadEn), 64'h0);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("rd_en", 64'(memReadEn), 64'h1);
        chk("rd_addr", 64'(memReadAddr), 64'h20);
        chkIdle("rd_r1");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkIdle("rd_r2");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkIdle("rd_r3");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("rd_first", 64'h104);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("rd_second", 64'h108);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("rd_third", 64'h10C);

        // Address wrap at 2^61-1.
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("wr_addr_top", 64'(memReadAddr), 64'h1FFF_FFFF_FFFF_FFFF);
        chkIdle("wr_r1");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("wr_addr_zero", 64'(memReadAddr), 64'h0);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkIdle("wr_r3");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("wr_a", 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("wr_b", 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("wr_c", 64'h0);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("wr_d", 64'h4);

        // Redirect together with an accept, then reset mid-stream.
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 1'b1, 64'h200, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chkIdle("rr_flush");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkIdle("rr_r2");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkIdle("rr_r3");
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("rr_first", 64'h200);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chkInst("rr_second", 64'h204);
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        chk("mr_en_now", 64'(memReadEn), 64'h0);
        cyc(1'b1, 1'b0, 64'h0, 1'b1);
        chk("mr_en", 64'(memReadEn), 64'h0);
        chk("mr_addr", 64'(memReadAddr), 64'h0);
        chkIdle("mr");
        for (int c = 0; c <= 3; c++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b1);
            if (c == 0) chk("mr_restart", 64'(memReadAddr), 64'h0);
            if (c == 3) chkInst("mr_first", 64'h0);
        end

`ifdef FETCH_STATS_EN
        // 10 issued requests, last redirect drops 2 in-flight responses.
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        chk("st_rst_f", 64'(statFetches), 64'h0);
        chk("st_rst_d", 64'(statDropped), 64'h0);
        for (int c = 0; c <= 17; c++) begin
            cyc(1'b0, (c == 6) || (c == 13) || (c == 16), 64'h0, 1'b0);
            if (c == 17) begin
                chk("st_fetches", 64'(statFetches), 64'd10);
                chk("st_dropped", 64'(statDropped), 64'd2);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
